mem_port_arbiter: RTL and testbench

- Shares the single external data-memory port (MemRead/MemWrite/MemAddr/MemData/MemOutput) between two requesters:
  - requester P: the Pipelined_Processor MEM stage;
  - requester D: the debug/program loader used by testbenches.
- Sequences each access over a fixed multi-cycle memory latency.
- Returns read data and a one-cycle ack.
- Drives a stall to the pipeline while the processor access is outstanding.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between the pipeline MEM stage
// (requester P) and the debug/program loader (requester D). Each access holds
// the memory command for MemLatency cycles, then returns read data and a
// one-cycle ack. Round-robin on ties, so P and D alternate under contention.
//
// Ports:
//   CLK, RST                      clock (rising edge), synchronous active-high reset
//   p_req/p_we/p_addr/p_wdata     processor request (level, held until p_ack)
//   p_rdata/p_ack                 processor read data and completion pulse
//   p_stall                       pipeline stall, combinational: p_req & ~p_ack
//   d_req/d_we/d_addr/d_wdata     debug request (level, held until d_ack)
//   d_rdata/d_ack                 debug read data and completion pulse
//   MemRead/MemWrite/MemAddr/MemData  memory command, registered
//   MemOutput                     memory read data
//   busy                          high whenever the arbiter is not idle
module mem_port_arbiter #(
    parameter int unsigned DataWidth  = 16,
    parameter int unsigned AddrWidth  = 16,
    parameter int unsigned MemLatency = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 p_req,
    input  logic                 p_we,
    input  logic [AddrWidth-1:0] p_addr,
    input  logic [DataWidth-1:0] p_wdata,
    output logic [DataWidth-1:0] p_rdata,
    output logic                 p_ack,
    output logic                 p_stall,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [AddrWidth-1:0] d_addr,
    input  logic [DataWidth-1:0] d_wdata,
    output logic [DataWidth-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [AddrWidth-1:0] MemAddr,
    output logic [DataWidth-1:0] MemData,
    input  logic [DataWidth-1:0] MemOutput,
    output logic                 busy
);

    localparam int unsigned CntWidth = 4;
    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(MemLatency - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } stateT;

    stateT                state, stateNxt;
    logic [CntWidth-1:0]  cnt, cntNxt;
    logic                 gnt, gntNxt;      // 0 = P, 1 = D
    logic                 lw, lwNxt;        // last winner
    logic                 capWe, capWeNxt;
    logic [AddrWidth-1:0] capAddr, capAddrNxt;
    logic [DataWidth-1:0] capWdata, capWdataNxt;

    logic                 memReadNxt, memWriteNxt;
    logic [AddrWidth-1:0] memAddrNxt;
    logic [DataWidth-1:0] memDataNxt;
    logic [DataWidth-1:0] pRdataNxt, dRdataNxt;
    logic                 pAckNxt, dAckNxt, busyNxt;
    logic                 pickD;

    // Round-robin: on a tie the requester that did not win last time goes next.
    assign pickD = (p_req && d_req) ? ~lw : d_req;

    assign p_stall = p_req & ~p_ack;

    // Next-state and registered-output logic.
    always_comb begin
        stateNxt    = state;
        cntNxt      = cnt;
        gntNxt      = gnt;
        lwNxt       = lw;
        capWeNxt    = capWe;
        capAddrNxt  = capAddr;
        capWdataNxt = capWdata;
        memReadNxt  = 1'b0;
        memWriteNxt = 1'b0;
        memAddrNxt  = '0;
        memDataNxt  = '0;
        pRdataNxt   = p_rdata;
        dRdataNxt   = d_rdata;
        pAckNxt     = 1'b0;
        dAckNxt     = 1'b0;
        busyNxt     = 1'b0;

        unique case (state)
            IDLE: begin
                if (p_req || d_req) begin
                    gntNxt      = pickD;
                    lwNxt       = pickD;
                    capWeNxt    = pickD ? d_we    : p_we;
                    capAddrNxt  = pickD ? d_addr  : p_addr;
                    capWdataNxt = pickD ? d_wdata : p_wdata;
                    cntNxt      = CntLoad;
                    stateNxt    = ACCESS;
                    // Command goes out in the first ACCESS cycle.
                    memReadNxt  = ~capWeNxt;
                    memWriteNxt = capWeNxt;
                    memAddrNxt  = capAddrNxt;
                    memDataNxt  = capWdataNxt;
                    busyNxt     = 1'b1;
                end
            end
            ACCESS: begin
                busyNxt = 1'b1;
                if (cnt == '0) begin
                    stateNxt = DONE;
                    if (!capWe) begin
                        if (gnt) dRdataNxt = MemOutput;
                        else     pRdataNxt = MemOutput;
                    end
                    pAckNxt = ~gnt;
                    dAckNxt = gnt;
                end else begin
                    cntNxt      = cnt - CntWidth'(1);
                    memReadNxt  = ~capWe;
                    memWriteNxt = capWe;
                    memAddrNxt  = capAddr;
                    memDataNxt  = capWdata;
                end
            end
            DONE: begin
                stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt      <= 1'b0;
            lw       <= 1'b1;
            capWe    <= 1'b0;
            capAddr  <= '0;
            capWdata <= '0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            MemAddr  <= '0;
            MemData  <= '0;
            p_rdata  <= '0;
            d_rdata  <= '0;
            p_ack    <= 1'b0;
            d_ack    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= stateNxt;
            cnt      <= cntNxt;
            gnt      <= gntNxt;
            lw       <= lwNxt;
            capWe    <= capWeNxt;
            capAddr  <= capAddrNxt;
            capWdata <= capWdataNxt;
            MemRead  <= memReadNxt;
            MemWrite <= memWriteNxt;
            MemAddr  <= memAddrNxt;
            MemData  <= memDataNxt;
            p_rdata  <= pRdataNxt;
            d_rdata  <= dRdataNxt;
            p_ack    <= pAckNxt;
            d_ack    <= dAckNxt;
            busy     <= busyNxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int ML = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        p_req, p_we, d_req, d_we;
    logic [15:0] p_addr, p_wdata, d_addr, d_wdata;
    logic [15:0] p_rdata, d_rdata;
    logic        p_ack, d_ack, p_stall;
    logic        MemRead, MemWrite, busy;
    logic [15:0] MemAddr, MemData, MemOutput;

    mem_port_arbiter #(.DataWidth(16), .AddrWidth(16), .MemLatency(ML)) dut (
        .CLK(CLK), .RST(RST),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ack(p_ack), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr),
        .MemData(MemData), .MemOutput(MemOutput), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Simple memory device attached to the port.
    logic [15:0] tbMem [256];
    always @(posedge CLK) if (MemWrite) tbMem[MemAddr[7:0]] <= MemData;
    assign MemOutput = tbMem[MemAddr[7:0]];

    // Transaction-level reference: one granted transaction at a time.
    logic [15:0] refMem [256];
    int          checks = 0;
    int          errors = 0;
    int          edgeNo = 0;
    bit          act = 0;
    int          gEdge = 0;
    bit          gWho, gWe;
    bit          lastW = 1;
    logic [15:0] gAddr, gData;
    logic [15:0] mP = 0, mD = 0;
    bit          logOn = 0;
    int          ackWho[$];
    int          ackEdge[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model over the coming edge, clock it, then compare outputs.
    task automatic tick();
        int j;
        bit eR, eW, eA, eDA, eB;
        logic [15:0] eAd, eDt;
        if (RST) begin
            act = 0; lastW = 1; mP = 0; mD = 0;
        end else begin
            j = edgeNo - gEdge;
            if (act && j == ML) begin
                if (gWe)       refMem[gAddr[7:0]] = gData;
                else if (gWho) mD = refMem[gAddr[7:0]];
                else           mP = refMem[gAddr[7:0]];
            end
            if ((!act || j >= ML + 2) && (p_req || d_req)) begin
                gWho  = (p_req && d_req) ? !lastW : d_req;
                lastW = gWho;
                gWe   = gWho ? d_we : p_we;
                gAddr = gWho ? d_addr : p_addr;
                gData = gWho ? d_wdata : p_wdata;
                gEdge = edgeNo;
                act   = 1;
            end
        end
        @(posedge CLK);
        #1;
        j = edgeNo - gEdge;
        eR = 0; eW = 0; eAd = 0; eDt = 0; eA = 0; eDA = 0; eB = 0;
        if (act && j < ML) begin
            eR = !gWe; eW = gWe; eAd = gAddr; eDt = gData; eB = 1;
        end else if (act && j == ML) begin
            eA = !gWho; eDA = gWho; eB = 1;
        end
        chk("MemRead",  32'(MemRead),  32'(eR));
        chk("MemWrite", 32'(MemWrite), 32'(eW));
        chk("MemAddr",  32'(MemAddr),  32'(eAd));
        chk("MemData",  32'(MemData),  32'(eDt));
        chk("p_ack",    32'(p_ack),    32'(eA));
        chk("d_ack",    32'(d_ack),    32'(eDA));
        chk("p_rdata",  32'(p_rdata),  32'(mP));
        chk("d_rdata",  32'(d_rdata),  32'(mD));
        chk("busy",     32'(busy),     32'(eB));
        chk("p_stall",  32'(p_stall),  32'(p_req & ~eA));
        if (logOn && p_ack) begin ackWho.push_back(0); ackEdge.push_back(edgeNo); end
        if (logOn && d_ack) begin ackWho.push_back(1); ackEdge.push_back(edgeNo); end
        edgeNo++;
    endtask

    initial begin
        logic [15:0] dPrev;
        bit          sawAck;
        for (int i = 0; i < 256; i++) begin
            tbMem[i]  = 16'(i * 257) ^ 16'h5a5a;
            refMem[i] = 16'(i * 257) ^ 16'h5a5a;
        end
        tbMem[4]  = 16'hFFEB;
        refMem[4] = 16'hFFEB;

        // Reset held two cycles with both requests high.
        RST = 1;
        p_req = 1; p_we = 0; p_addr = 16'h0001; p_wdata = 16'h0;
        d_req = 1; d_we = 0; d_addr = 16'h0002; d_wdata = 16'h0;
        tick();
        tick();
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_p_rdata", 32'(p_rdata), 32'd0);

        // Continuous contention: P wins first, then strict alternation.
        RST = 0;
        logOn = 1;
        tick();
        chk("first_grant_addr", 32'(MemAddr), 32'h0001);
        chk("first_grant_rd",   32'(MemRead), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        logOn = 0;
        chk("cont_count", 32'(ackWho.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < ackWho.size(); i++)
            chk("cont_order", 32'(ackWho[i]), 32'(i % 2));
        for (int i = 1; i < 4 && i < ackEdge.size(); i++)
            chk("cont_spacing", 32'(ackEdge[i] - ackEdge[i-1]), 32'(ML + 2));
        p_req = 0; d_req = 0;
        for (int i = 0; i < 6; i++) tick();

        // Single P read, with an address change in the middle of the access.
        p_req = 1; p_we = 0; p_addr = 16'h0004;
        #1;
        chk("stall_c0", 32'(p_stall), 32'd1);
        tick();
        chk("rd_c1_memread", 32'(MemRead), 32'd1);
        chk("rd_c1_addr",    32'(MemAddr), 32'h0004);
        chk("rd_c1_stall",   32'(p_stall), 32'd1);
        p_addr = 16'h0008;
        tick();
        chk("rd_c2_addr",    32'(MemAddr), 32'h0004);
        chk("rd_c2_stall",   32'(p_stall), 32'd1);
        tick();
        chk("rd_c3_ack",     32'(p_ack),   32'd1);
        chk("rd_c3_rdata",   32'(p_rdata), 32'hFFEB);
        chk("rd_c3_stall",   32'(p_stall), 32'd0);
        p_req = 0;
        for (int i = 0; i < 2; i++) tick();

        // D write: strobes for two cycles, ack, read data untouched.
        dPrev = d_rdata;
        d_req = 1; d_we = 1; d_addr = 16'h0010; d_wdata = 16'h1234;
        tick();
        chk("wr_c1_memwrite", 32'(MemWrite), 32'd1);
        chk("wr_c1_data",     32'(MemData),  32'h1234);
        tick();
        chk("wr_c2_memwrite", 32'(MemWrite), 32'd1);
        tick();
        chk("wr_c3_ack",      32'(d_ack),    32'd1);
        chk("wr_c3_rdata",    32'(d_rdata),  32'(dPrev));
        d_req = 0; d_we = 0;
        for (int i = 0; i < 2; i++) tick();

        // Reset in the first ACCESS cycle aborts the read without an ack.
        p_req = 1; p_we = 0; p_addr = 16'h0004;
        tick();
        chk("abort_pre_rd", 32'(MemRead), 32'd1);
        RST = 1;
        tick();
        chk("abort_memread", 32'(MemRead), 32'd0);
        chk("abort_busy",    32'(busy),    32'd0);
        RST = 0; p_req = 0;
        sawAck = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (p_ack) sawAck = 1;
        end
        chk("abort_no_ack", 32'(sawAck), 32'd0);

        // Random traffic from both requesters.
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (p_req && p_ack) p_req = 0;
            else if (!p_req && $urandom_range(2) == 0) begin
                p_req = 1; p_we = 1'($urandom_range(1));
                p_addr = {8'($urandom), 8'($urandom_range(15))}; p_wdata = 16'($urandom);
            end else if (p_req && $urandom_range(3) == 0) begin
                p_addr = {8'($urandom), 8'($urandom_range(15))}; p_wdata = 16'($urandom);
            end
            if (d_req && d_ack) d_req = 0;
            else if (!d_req && $urandom_range(2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(1));
                d_addr = {8'($urandom), 8'($urandom_range(15))}; d_wdata = 16'($urandom);
            end else if (d_req && $urandom_range(3) == 0) begin
                d_addr = {8'($urandom), 8'($urandom_range(15))}; d_wdata = 16'($urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
